apb_completer_regfile: RTL and testbench

//  APB completer (slave) endpoint for one PSELx line of the peripheral bridge.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_reg_bank.sv | 77 +++++++
 rtl/apb_completer_regfile.sv | 140 ++++++++++++++
 tb/tb_apb_completer_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer register file.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int unsigned PPROT_PRIV_BIT = 0;

  function automatic logic [7:0] lane_merge(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       strb
  );
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: byte-lane writes, one-cycle write
// strobes, read mux with the live status word in the top slot.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned         DATASIZE  = 32,
  parameter int unsigned         NUM_REGS  = 8,
  parameter int unsigned         IDX_W     = 3,
  parameter logic [DATASIZE-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATASIZE-1:0]          wdata,
  input  logic [DATASIZE/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]             rd_idx,
  input  logic [DATASIZE-1:0]          hw_status,
  output logic [DATASIZE-1:0]          rd_data,
  output logic [NUM_REGS*DATASIZE-1:0] reg_flat,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned RW_REGS = NUM_REGS - 1;
  localparam int unsigned LANES   = DATASIZE / 8;

  logic [DATASIZE-1:0] regs_q [RW_REGS];
  logic [DATASIZE-1:0] regs_d [RW_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [NUM_REGS-1:0] wr_pulse_d;

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int unsigned i = 0; i < RW_REGS; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        for (int unsigned b = 0; b < LANES; b++) begin
          regs_d[i][b*8 +: 8] = lane_merge(regs_q[i][b*8 +: 8], wdata[b*8 +: 8], wstrb[b]);
        end
        wr_pulse_d[i] = 1'b1;
      end
    end
  end

  // Status slot defaults to hw_status so out-of-range indices never read storage.
  always_comb begin
    rd_data = hw_status;
    for (int unsigned i = 0; i < RW_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int unsigned i = 0; i < RW_REGS; i++) begin
      reg_flat[i*DATASIZE +: DATASIZE] = regs_q[i];
    end
    reg_flat[RW_REGS*DATASIZE +: DATASIZE] = hw_status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RW_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer endpoint: setup/access FSM, wait-state counter and access
// decode in front of a byte-addressable register bank.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int unsigned         ADDRSIZE    = 32,
  parameter int unsigned         DATASIZE    = 32,
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_STATES = 1,
  parameter int unsigned         PRIV_WRITE  = 1,
  parameter logic [DATASIZE-1:0] RESET_VAL   = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDRSIZE-1:0]          PADDR,
  input  logic [DATASIZE-1:0]          PWDATA,
  input  logic [DATASIZE/8-1:0]        PSTRB,
  input  logic [2:0]                   PPROT,
  input  logic                         stall_in,
  input  logic [DATASIZE-1:0]          hw_status,
  output logic                         PREADY,
  output logic [DATASIZE-1:0]          PRDATA,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATASIZE-1:0] reg_flat,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned         IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned         STRB_W   = DATASIZE / 8;
  localparam logic [ADDRSIZE-3:0] WORDS    = (ADDRSIZE-2)'(NUM_REGS);
  localparam logic [ADDRSIZE-3:0] STAT_IDX = (ADDRSIZE-2)'(NUM_REGS - 1);

  apb_state_e          state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic [DATASIZE-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                err_q, err_d;

  logic [ADDRSIZE-3:0] word_addr;
  logic                dec_err;
  logic                pready;
  logic                complete;
  logic                wr_en;
  logic [DATASIZE-1:0] rd_data;
  logic                pprot_unused;

  assign pprot_unused = ^PPROT[2:1];
  assign word_addr    = PADDR[ADDRSIZE-1:2];

  // Full word address is compared so aliases above the bank also fault.
  assign dec_err = (PADDR[1:0] != 2'b00)
                || (word_addr >= WORDS)
                || (PWRITE && (word_addr == STAT_IDX))
                || ((PRIV_WRITE != 0) && PWRITE && !PPROT[PPROT_PRIV_BIT]);

  assign pready   = (state_q == ACCESS) && (wait_cnt_q == 4'd0) && !stall_in;
  assign complete = pready && PSEL && PENABLE;
  assign wr_en    = complete && write_q && !err_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d    = ACCESS;
          wait_cnt_d = 4'(WAIT_STATES);
          idx_d      = PADDR[IDX_W+1:2];
          write_d    = PWRITE;
          wdata_d    = PWDATA;
          strb_d     = PSTRB;
          err_d      = dec_err;
        end
      end
      ACCESS: begin
        if (!PSEL || complete) begin
          state_d = IDLE;
        end
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      err_q      <= err_d;
    end
  end

  apb_reg_bank #(
    .DATASIZE  (DATASIZE),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk       (PCLK),
    .rst       (PRESET),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wdata     (wdata_q),
    .wstrb     (strb_q),
    .rd_idx    (idx_q),
    .hw_status (hw_status),
    .rd_data   (rd_data),
    .reg_flat  (reg_flat),
    .wr_pulse  (wr_pulse)
  );

  assign PREADY  = pready;
  assign PSLVERR = pready && err_q;
  assign PRDATA  = (pready && !write_q && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed plus randomized bench for apb_completer_regfile with a word-array
// reference model of the register file.
module tb_apb_completer_regfile;

  localparam int unsigned NREG = 8;
  localparam int unsigned WS   = 1;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [2:0]   PPROT;
  logic         stall_in;
  logic [31:0]  hw_status;
  logic         PREADY;
  logic [31:0]  PRDATA;
  logic         PSLVERR;
  logic [255:0] reg_flat;
  logic [7:0]   wr_pulse;

  int unsigned  pass_cnt  = 0;
  int unsigned  total_cnt = 0;
  logic [31:0]  model [NREG];

  always #5 PCLK = ~PCLK;

  apb_completer_regfile #(
    .ADDRSIZE    (32),
    .DATASIZE    (32),
    .NUM_REGS    (NREG),
    .WAIT_STATES (WS),
    .PRIV_WRITE  (1),
    .RESET_VAL   (32'h0)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT),
    .stall_in  (stall_in),
    .hw_status (hw_status),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .reg_flat  (reg_flat),
    .wr_pulse  (wr_pulse)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < NREG; i++) begin
      f[i*32 +: 32] = (i == NREG - 1) ? hw_status : model[i];
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input int stall_n);
    int unsigned idx;
    bit          err;
    int          exp_n;
    int          n;
    bit          done;
    logic [31:0] exp_rd;
    logic [31:0] mask;

    idx    = addr >> 2;
    err    = (addr % 4 != 0) || (idx >= NREG) || (wr && idx == NREG - 1) || (wr && !prot[0]);
    exp_n  = ((WS > stall_n) ? WS : stall_n) + 1;

    hw_status = $urandom;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot; stall_in = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    PADDR   = $urandom;
    PWDATA  = $urandom;

    n = 0;
    done = 0;
    while (!done) begin
      n++;
      stall_in = (n <= stall_n);
      #1;
      chk("pready_timing", PREADY, (n == exp_n));
      if (PREADY === 1'b1) begin
        if (err || wr) exp_rd = 32'h0;
        else if (idx == NREG - 1) exp_rd = hw_status;
        else exp_rd = model[idx];
        chk("pslverr", PSLVERR, err);
        chk("prdata", PRDATA, exp_rd);
        done = 1;
      end else begin
        chk("prdata_wait", PRDATA, 32'h0);
        if (n >= 40) begin
          chk("pready_timeout", 1'b0, 1'b1);
          done = 1;
        end
      end
      @(posedge PCLK); #1;
    end

    PSEL = 1'b0; PENABLE = 1'b0; stall_in = 1'b0;
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) mask[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
      model[idx] = (model[idx] & ~mask) | (data & mask);
      chk("wr_pulse_hit", wr_pulse, 8'h1 << idx);
    end else begin
      chk("wr_pulse_none", wr_pulse, 8'h0);
    end
    chk("reg_flat", reg_flat, model_flat());
    chk("pready_idle", PREADY, 1'b0);
    @(posedge PCLK); #1;
    chk("wr_pulse_clear", wr_pulse, 8'h0);
  endtask

  initial begin
    int unsigned ridx;
    logic [31:0] raddr;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; stall_in = 1'b0;
    hw_status = 32'h0000_1234;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    chk("rst_pready", PREADY, 1'b0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_wr_pulse", wr_pulse, 8'h0);
    chk("rst_reg_flat", reg_flat, model_flat());

    xfer(1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b001, 0);
    xfer(1, 32'h04, 32'h0000_00AA, 4'h1, 3'b001, 0);
    chk("reg1_merged", model[1], 32'hDEAD_BEAA);
    xfer(0, 32'h04, 32'h0, 4'h0, 3'b000, 0);
    xfer(0, 32'h1C, 32'h0, 4'hF, 3'b001, 0);
    xfer(1, 32'h1C, 32'h1111_2222, 4'hF, 3'b001, 0);
    xfer(1, 32'h20, 32'h3333_4444, 4'hF, 3'b001, 0);
    xfer(0, 32'h06, 32'h0, 4'h0, 3'b001, 0);
    xfer(1, 32'h08, 32'h5555_6666, 4'hF, 3'b000, 0);
    xfer(1, 32'h0C, 32'h7777_8888, 4'h0, 3'b001, 0);
    xfer(0, 32'h04, 32'h0, 4'h0, 3'b001, 3);
    xfer(1, 32'h10, 32'hCAFE_F00D, 4'hA, 3'b011, 2);

    for (int k = 0; k < 24; k++) begin
      ridx  = $urandom_range(0, 9);
      raddr = ridx * 4;
      if ($urandom_range(0, 7) == 0) raddr = raddr + $urandom_range(1, 3);
      xfer(1'($urandom_range(0, 1)), raddr, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 3));
    end

    // Abort in the first access cycle must leave the bank untouched.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08;
    PWDATA = 32'h0BAD_0BAD; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_pready", PREADY, 1'b0);
    @(posedge PCLK); #1;
    chk("abort_wr_pulse", wr_pulse, 8'h0);
    chk("abort_reg_flat", reg_flat, model_flat());

    // PENABLE without a setup phase is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h08;
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK); #1;
      chk("idle_penable_pready", PREADY, 1'b0);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("idle_penable_wr_pulse", wr_pulse, 8'h0);
    chk("idle_penable_reg_flat", reg_flat, model_flat());

    // Reset arriving on the completion edge of a write wins.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08;
    PWDATA = 32'h5A5A_5A5A; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("prerst_pready", PREADY, 1'b1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    chk("midrst_pready", PREADY, 1'b0);
    chk("midrst_wr_pulse", wr_pulse, 8'h0);
    chk("midrst_reg_flat", reg_flat, model_flat());

    xfer(0, 32'h08, 32'h0, 4'h0, 3'b001, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
